// File: rtl/bcd_down_timer.sv
// Loadable BCD countdown timer with an IDLE/RUN/PAUSE/DONE control FSM.
// count is always valid BCD, and DONE is entered before any wrap past zero.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  paused,
   output logic                  expired,
   output logic                  done_p,
   output logic [1:0]            state_dbg
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   count_n;
   logic           done_n;
   logic [W-1:0]   load_clean;
   logic [W-1:0]   count_dec;

   // Any nibble above 9 is clamped to 9, so count can never hold non-BCD.
   function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9)
            r[4*i +: 4] = 4'd9;
         else
            r[4*i +: 4] = v[4*i +: 4];
      end
      return r;
   endfunction

   // Borrow ripples upward from digit 0 until a non-zero digit absorbs it.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign load_clean = sanitise(load_val);
   assign count_dec  = bcd_dec(count);

   // State register, count and the done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         count  <= '0;
         done_p <= 1'b0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         done_p <= done_n;
      end
   end

   // Next state; input priority is load > stop > start > tick.
   always_comb begin
      state_n = state;
      count_n = count;
      done_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               count_n = load_clean;
            end else if (start) begin
               if (count == '0) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (load) begin
               count_n = load_clean;
               state_n = S_IDLE;
            end else if (stop) begin
               state_n = S_PAUSE;
            end else if (tick && (count != '0)) begin
               count_n = count_dec;
               if (count_dec == '0) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (load) begin
               count_n = load_clean;
               state_n = S_IDLE;
            end else if (!stop && start) begin
               state_n = S_RUN;
            end
         end
         S_DONE: begin
            if (load) begin
               count_n = load_clean;
               state_n = S_IDLE;
            end else begin
               count_n = '0;
            end
         end
         default: begin
            state_n = S_IDLE;
            count_n = '0;
         end
      endcase
   end

   // Status flags decode straight from the registered state (one-hot or all 0).
   always_comb begin
      running   = (state == S_RUN);
      paused    = (state == S_PAUSE);
      expired   = (state == S_DONE);
      state_dbg = state;
   end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: decimal-integer reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bcd_down_timer;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n, tick, load, start, stop;
   logic [W-1:0]  load_val;
   logic [W-1:0]  count;
   logic          running, paused, expired, done_p;
   logic [1:0]    state_dbg;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: count kept as a plain decimal integer.
   int m_count = 0;
   int m_mode  = M_IDLE;
   bit m_done  = 1'b0;

   bcd_down_timer #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .count(count), .running(running),
      .paused(paused), .expired(expired), .done_p(done_p), .state_dbg(state_dbg)
   );

   // Clock / reset
   always #5 clk = ~clk;

   function automatic int clamp_val(input logic [W-1:0] v);
      int r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         int d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int n);
      logic [W-1:0] r = '0;
      int x = n;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_count = 0;
         m_mode  = M_IDLE;
         m_done  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (load) begin
            m_count = clamp_val(load_val);
            m_mode  = M_IDLE;
         end else begin
            case (m_mode)
               M_IDLE:  if (start) begin
                           m_mode = (m_count == 0) ? M_DONE : M_RUN;
                           m_done = (m_count == 0);
                        end
               M_RUN:   if (stop) m_mode = M_PAUSE;
                        else if (tick) begin
                           m_count = m_count - 1;
                           if (m_count == 0) begin
                              m_mode = M_DONE;
                              m_done = 1'b1;
                           end
                        end
               M_PAUSE: if (!stop && start) m_mode = M_RUN;
               default: ;
            endcase
         end
      end
   end

   // Scoreboard compare
   task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("count",   count,          to_bcd(m_count));
         cmp("running", W'(running),    W'(m_mode == M_RUN));
         cmp("paused",  W'(paused),     W'(m_mode == M_PAUSE));
         cmp("expired", W'(expired),    W'(m_mode == M_DONE));
         cmp("done_p",  W'(done_p),     W'(m_done));
      end
   end

   // Driver tasks
   task automatic step(input bit ld, input logic [W-1:0] lv, input bit st,
                       input bit sp, input bit tk);
      load = ld; load_val = lv; start = st; stop = sp; tick = tk;
      @(posedge clk); #1;
      load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
   endtask

   task automatic flags(input string name, input bit r, input bit p, input bit e, input bit d);
      cmp({name, "_running"}, W'(running), W'(r));
      cmp({name, "_paused"},  W'(paused),  W'(p));
      cmp({name, "_expired"}, W'(expired), W'(e));
      cmp({name, "_done_p"},  W'(done_p),  W'(d));
   endtask

   initial begin
      rst_n = 1'b0; tick = 0; load = 0; start = 0; stop = 0; load_val = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      cmp("reset_count", count, 8'h00);
      flags("reset", 0, 0, 0, 0);
      rst_n = 1'b1;

      // 1: 25 down to 00
      step(1, 8'h25, 0, 0, 0);
      cmp("t1_load", count, 8'h25);
      step(0, '0, 1, 0, 0);
      flags("t1_start", 1, 0, 0, 0);
      for (int k = 1; k <= 25; k++) begin
         step(0, '0, 0, 0, 1);
         if (k == 1)  cmp("t1_first", count, 8'h24);
         if (k == 16) cmp("t1_mid", count, 8'h09);
         if (k == 25) begin
            cmp("t1_zero", count, 8'h00);
            flags("t1_end", 0, 0, 1, 1);
         end
         idle(2);
      end
      cmp("t1_pulse_gone", W'(done_p), 8'h00);

      // 2: borrow from 10
      step(1, 8'h10, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 1);
      cmp("t2_borrow", count, 8'h09);
      for (int k = 0; k < 9; k++) begin
         step(0, '0, 0, 0, 1);
         if (count == 8'h99) cmp("t2_no_wrap", count, 8'h00);
      end
      cmp("t2_zero", count, 8'h00);
      flags("t2_end", 0, 0, 1, 1);

      // 3: pause at 07
      step(1, 8'h07, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 1);
      cmp("t3_hold", count, 8'h07);
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 1);
      cmp("t3_hold2", count, 8'h07);
      flags("t3_pause", 0, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 1);
      cmp("t3_resume", count, 8'h06);
      flags("t3_run", 1, 0, 0, 0);

      // 4: sanitise and zero start
      step(1, 8'hA3, 0, 0, 0);
      cmp("t4_clamp", count, 8'h93);
      step(1, 8'h00, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      flags("t4_done", 0, 0, 1, 1);
      idle(1);
      flags("t4_after", 0, 0, 1, 0);

      // 5: reset mid-count
      step(1, 8'h42, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      rst_n = 1'b0;
      step(0, '0, 1, 0, 1);
      rst_n = 1'b1;
      cmp("t5_count", count, 8'h00);
      flags("t5", 0, 0, 0, 0);

      // 6: load+start, DONE ignores start/tick
      step(1, 8'h15, 1, 0, 0);
      cmp("t6_load", count, 8'h15);
      flags("t6_idle", 0, 0, 0, 0);
      step(1, 8'h01, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 1);
      step(0, '0, 1, 0, 1);
      cmp("t6_done_hold", count, 8'h00);
      flags("t6_done", 0, 0, 1, 0);
      step(1, 8'h03, 0, 0, 0);
      cmp("t6_reload", count, 8'h03);
      flags("t6_idle2", 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         step($urandom_range(0, 15) == 0, W'($urandom_range(0, (1 << W) - 1)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1);
      end
      rst_n = 1'b1;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
